// File: rtl/imm_gen_pipe.sv
// Registered multi-lane immediate generator with a 1-entry skid buffer and kill.
// Optional feature: define IMM_ZIMM_EN to decode type code 5 as the CSR zimm immediate.
module imm_gen_pipe #(
  parameter int WAY      = 2,
  parameter int DATA_LEN = 32,
  parameter int INSN_LEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WAY*INSN_LEN-1:0]   inst,
  input  logic [WAY*3-1:0]          imm_type,
  input  logic [WAY-1:0]            lane_en,
  input  logic                      kill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WAY*DATA_LEN-1:0]   imm,
  output logic [WAY-1:0]            imm_bad
);

  // Returns {illegal, 32-bit immediate}; illegal codes fall back to the I-type value.
  function automatic logic [32:0] decode32(input logic [31:0] i, input logic [2:0] t);
    logic [31:0] imm_i;
    imm_i = {{21{i[31]}}, i[30:20]};
    case (t)
      3'd0:    decode32 = {1'b0, imm_i};
      3'd1:    decode32 = {1'b0, {21{i[31]}}, i[30:25], i[11:7]};
      3'd2:    decode32 = {1'b0, i[31:12], 12'b0};
      3'd3:    decode32 = {1'b0, {12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    decode32 = {1'b0, {20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
`ifdef IMM_ZIMM_EN
      3'd5:    decode32 = {1'b0, 27'd0, i[19:15]};
`endif
      default: decode32 = {1'b1, imm_i};
    endcase
  endfunction

  function automatic logic [DATA_LEN-1:0] sext32(input logic [31:0] v);
    sext32       = {DATA_LEN{v[31]}};
    sext32[31:0] = v;
  endfunction

  logic [WAY*DATA_LEN-1:0] dec_imm;
  logic [WAY-1:0]          dec_bad;
  logic [32:0]             lane_dec;

  logic                    in_ready_q,  in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    skid_full_q, skid_full_d;
  logic [WAY*DATA_LEN-1:0] out_imm_q,   out_imm_d;
  logic [WAY-1:0]          out_bad_q,   out_bad_d;
  logic [WAY*DATA_LEN-1:0] skid_imm_q,  skid_imm_d;
  logic [WAY-1:0]          skid_bad_q,  skid_bad_d;

  logic                    accept;
  logic                    out_free;

  always_comb begin
    dec_imm  = '0;
    dec_bad  = '0;
    lane_dec = '0;
    for (int l = 0; l < WAY; l++) begin
      lane_dec = decode32(inst[l*INSN_LEN +: 32], imm_type[l*3 +: 3]);
      if (lane_en[l]) begin
        dec_imm[l*DATA_LEN +: DATA_LEN] = sext32(lane_dec[31:0]);
        dec_bad[l]                      = lane_dec[32];
      end else begin
        dec_imm[l*DATA_LEN +: DATA_LEN] = '0;
        dec_bad[l]                      = 1'b0;
      end
    end
  end

  // Skid drains before new input so bundle order is preserved; kill drops everything.
  always_comb begin
    accept      = in_valid & in_ready_q & ~kill;
    out_free    = ~out_valid_q | out_ready;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    out_imm_d   = out_imm_q;
    out_bad_d   = out_bad_q;
    skid_imm_d  = skid_imm_q;
    skid_bad_d  = skid_bad_q;
    if (kill) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_imm_d   = skid_imm_q;
        out_bad_d   = skid_bad_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_bad_d   = dec_bad;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_full_d = 1'b1;
        skid_imm_d  = dec_imm;
        skid_bad_d  = dec_bad;
      end else begin
        skid_full_d = skid_full_q;
      end
    end
    in_ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      out_imm_q   <= '0;
      out_bad_q   <= '0;
      skid_imm_q  <= '0;
      skid_bad_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      out_imm_q   <= out_imm_d;
      out_bad_q   <= out_bad_d;
      skid_imm_q  <= skid_imm_d;
      skid_bad_q  <= skid_bad_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = out_imm_q;
  assign imm_bad   = out_bad_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: queue-based reference model plus directed literal checks.
// Honours IMM_ZIMM_EN the same way as the design.
module tb_imm_gen_pipe;
  localparam int WAY = 2;
  localparam int DL  = 32;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, kill, out_valid, out_ready;
  logic [WAY*32-1:0] inst;
  logic [WAY*3-1:0]  imm_type;
  logic [WAY-1:0]    lane_en;
  logic [WAY*DL-1:0] imm;
  logic [WAY-1:0]    imm_bad;

  logic        in_valid64, in_ready64, out_valid64;
  logic [31:0] inst64;
  logic [2:0]  type64;
  logic [0:0]  en64, bad64;
  logic [63:0] imm64;
  logic        kill64 = 1'b0;
  logic        out_ready64 = 1'b1;

  int ntotal = 0;
  int nfail  = 0;

  typedef struct {
    logic [WAY*DL-1:0] imm;
    logic [WAY-1:0]    bad;
  } bundle_t;
  bundle_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.WAY(WAY), .DATA_LEN(DL), .INSN_LEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .imm_type(imm_type), .lane_en(lane_en), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .imm_bad(imm_bad)
  );

  imm_gen_pipe #(.WAY(1), .DATA_LEN(64), .INSN_LEN(32)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .inst(inst64), .imm_type(type64), .lane_en(en64), .kill(kill64),
    .out_valid(out_valid64), .out_ready(out_ready64), .imm(imm64), .imm_bad(bad64)
  );

  function automatic longint sext(longint v, int bits);
    longint m;
    m = longint'(1) << (bits - 1);
    return (v ^ m) - m;
  endfunction

  // Reference immediate as a signed number assembled from instruction fields; bit 64 = illegal.
  function automatic logic [64:0] ref_lane(logic [31:0] i, logic [2:0] t, logic en);
    longint w, v;
    logic   b;
    w = longint'(i);
    b = 1'b0;
    if (!en) return 65'd0;
    case (t)
      3'd0: v = sext(w >> 20, 12);
      3'd1: v = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
      3'd2: v = sext(w & 64'hFFFFF000, 32);
      3'd3: v = sext(((w >> 31) << 20) | (((w >> 12) & 255) << 12) |
                     (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      3'd4: v = sext(((w >> 31) << 12) | (((w >> 7) & 1) << 11) |
                     (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
`ifdef IMM_ZIMM_EN
      3'd5: v = (w >> 15) & 31;
`endif
      default: begin v = sext(w >> 20, 12); b = 1'b1; end
    endcase
    return {b, 64'(v)};
  endfunction

  function automatic bundle_t make_bundle(logic [WAY*32-1:0] ins, logic [WAY*3-1:0] ty,
                                          logic [WAY-1:0] en);
    bundle_t     bb;
    logic [64:0] r;
    for (int l = 0; l < WAY; l++) begin
      r = ref_lane(ins[l*32 +: 32], ty[l*3 +: 3], en[l]);
      bb.imm[l*DL +: DL] = r[DL-1:0];
      bb.bad[l]          = r[64];
    end
    return bb;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    ntotal++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of main-DUT inputs, advance the model, then compare at the next negedge.
  task automatic step(logic iv, logic [WAY*32-1:0] ins, logic [WAY*3-1:0] ty,
                      logic [WAY-1:0] en, logic kl, logic ordy);
    int sz;
    in_valid = iv; inst = ins; imm_type = ty; lane_en = en; kill = kl; out_ready = ordy;
    sz = q.size();
    if (kl) begin
      q.delete();
    end else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (iv && sz < 2) q.push_back(make_bundle(ins, ty, en));
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("imm", 64'(imm), 64'(q[0].imm));
      check("imm_bad", 64'(imm_bad), 64'(q[0].bad));
    end
  endtask

  logic [31:0] t2_inst[4] = '{32'h00112623, 32'h12345037, 32'h0080006F, 32'hFE000EE3};
  logic [2:0]  t2_type[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] t2_exp[4]  = '{32'h0000000C, 32'h12345000, 32'h00000008, 32'hFFFFFFFC};
  logic [64:0] pin;

  initial begin
    reset = 1'b1; in_valid = 1'b1; inst = '1; imm_type = '0; lane_en = '1;
    kill = 1'b0; out_ready = 1'b0;
    in_valid64 = 1'b1; inst64 = 32'hFFF00093; type64 = 3'd0; en64 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_imm_bad", 64'(imm_bad), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);

    pin = ref_lane(32'hFE000EE3, 3'd4, 1'b1);
    check("model_B", pin[63:0], 64'hFFFFFFFFFFFFFFFC);
    pin = ref_lane(32'h0080006F, 3'd3, 1'b1);
    check("model_J", pin[63:0], 64'h0000000000000008);

    // Test 1: I-type addi -1
    step(1'b1, {32'h0, 32'hFFF00093}, {3'd0, 3'd0}, 2'b11, 1'b0, 1'b1);
    check("t1_imm0", 64'(imm[31:0]), 64'hFFFFFFFF);
    check("t1_bad0", 64'(imm_bad[0]), 64'd0);

    // Test 2: S/U/J/B on lane 0 and lane 1
    for (int k = 0; k < 4; k++) begin
      step(1'b1, {t2_inst[k], t2_inst[k]}, {t2_type[k], t2_type[k]}, 2'b11, 1'b0, 1'b1);
      check("t2_lane0", 64'(imm[31:0]), 64'(t2_exp[k]));
      check("t2_lane1", 64'(imm[63:32]), 64'(t2_exp[k]));
    end

    // Test 5: lane enable and illegal type
    step(1'b1, {32'hFFF00093, 32'hFFF00093}, {3'd7, 3'd6}, 2'b01, 1'b0, 1'b1);
    check("t5_imm0", 64'(imm[31:0]), 64'hFFFFFFFF);
    check("t5_imm1", 64'(imm[63:32]), 64'd0);
    check("t5_bad", 64'(imm_bad), 64'b01);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Test 3: backpressure A, B, C
    step(1'b1, {32'h0, 32'hAAAAA037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b0);
    check("t3_A_out", 64'(imm[31:0]), 64'hAAAAA000);
    step(1'b1, {32'h0, 32'hBBBBB037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b0);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    step(1'b1, {32'h0, 32'hCCCCC037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b0);
    check("t3_A_held", 64'(imm[31:0]), 64'hAAAAA000);
    check("t3_C_blocked", 64'(in_ready), 64'd0);
    step(1'b1, {32'h0, 32'hCCCCC037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b1);
    check("t3_B_out", 64'(imm[31:0]), 64'hBBBBB000);
    check("t3_ready_back", 64'(in_ready), 64'd1);
    step(1'b1, {32'h0, 32'hCCCCC037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b1);
    check("t3_C_out", 64'(imm[31:0]), 64'hCCCCC000);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("t3_drained", 64'(out_valid), 64'd0);

    // Test 4: kill with A on output, B in skid, C offered
    step(1'b1, {32'h0, 32'hAAAAA037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b0);
    step(1'b1, {32'h0, 32'hBBBBB037}, {3'd0, 3'd2}, 2'b01, 1'b0, 1'b0);
    step(1'b1, {32'h0, 32'hCCCCC037}, {3'd0, 3'd2}, 2'b01, 1'b1, 1'b0);
    check("t4_valid", 64'(out_valid), 64'd0);
    check("t4_ready", 64'(in_ready), 64'd1);
    repeat (3) step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Test 6: 64-bit lane
    in_valid64 = 1'b1; inst64 = 32'h80000037; type64 = 3'd2; en64 = 1'b1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("t6_U64", imm64, 64'hFFFFFFFF80000000);
    inst64 = 32'hFE000EE3; type64 = 3'd4;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("t6_B64", imm64, 64'hFFFFFFFFFFFFFFFC);
    inst64 = 32'h000FD073; type64 = 3'd5;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    in_valid64 = 1'b0;
`ifdef IMM_ZIMM_EN
    check("t6_zimm", imm64, 64'h1F);
    check("t6_zimm_bad", 64'(bad64), 64'd0);
`else
    check("t6_zimm_as_I", imm64, 64'h0);
    check("t6_zimm_bad", 64'(bad64), 64'd1);
`endif
    check("t6_valid64", 64'(out_valid64), 64'd1);

    // Randomised traffic against the queue model
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom},
           {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))},
           2'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", ntotal, nfail);
    $finish;
  end
endmodule
